// File: rtl/mem_access_unit.sv
// Memory stage: issues one data-memory access per load/store and registers the MEM/WB result.
// Latency: 1 cycle for ALU/misaligned ops, 4 cycles minimum for loads/stores (IDLE, REQ, RESP, DONE).
// Backpressure: stall_req holds EX/MEM until DONE. A request is held stable while dmem_req_ready is low.
//
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   me_*                     EX/MEM pipeline register outputs (operation, address, store data, rd, pc/inst)
//   stall_req                hold EX/MEM and earlier stages while an access is in flight
//   dmem_req_* / dmem_addr / dmem_wen / dmem_wdata / dmem_wmask
//                            registered request, held for the whole REQ state
//   dmem_resp_valid / dmem_rdata
//                            response, only sampled in RESP
//   wb_*                     registered MEM/WB result
//   misalign_err             one-cycle flag issued with the faulting instruction's wb update
module mem_access_unit #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            me_mem_rena,
    input  logic            me_mem_wena,
    input  logic            me_mem_ext_un,
    input  logic            me_mem_to_reg,
    input  logic [7:0]      me_mem_byte_enable,
    input  logic [XLEN-1:0] me_alu_result,
    input  logic [XLEN-1:0] me_new_rs2_data,
    input  logic            me_rd_wena,
    input  logic [4:0]      me_rd_waddr,
    input  logic [XLEN-1:0] me_pc,
    input  logic [ILEN-1:0] me_inst,
    output logic            stall_req,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_wen,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wmask,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_rd_wena,
    output logic [4:0]      wb_rd_waddr,
    output logic [XLEN-1:0] wb_rd_wdata,
    output logic [XLEN-1:0] wb_pc,
    output logic [ILEN-1:0] wb_inst,
    output logic            misalign_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t          state_q;
    logic            req_valid_q;
    logic [XLEN-1:0] req_addr_q;
    logic            req_wen_q;
    logic [XLEN-1:0] req_wdata_q;
    logic [7:0]      req_wmask_q;
    logic [XLEN-1:0] load_buf_q;
    logic            wb_rd_wena_q;
    logic [4:0]      wb_rd_waddr_q;
    logic [XLEN-1:0] wb_rd_wdata_q;
    logic [XLEN-1:0] wb_pc_q;
    logic [ILEN-1:0] wb_inst_q;
    logic            misalign_err_q;

    logic            mem_op;
    logic [2:0]      off;
    logic [15:0]     be_wide;
    logic            misaligned;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] ld_val;

    assign mem_op     = me_mem_rena | me_mem_wena;
    assign off        = me_alu_result[2:0];
    // Mask shifted into a 16-bit window: any lane past byte 7 means the access crosses the doubleword.
    assign be_wide    = {8'h00, me_mem_byte_enable} << off;
    assign misaligned = mem_op & (|be_wide[15:8]);

    // Gated by rst so the stall drops the moment reset is asserted, not at the next edge.
    assign stall_req = rst & (((state_q == IDLE) & mem_op & ~misaligned) |
                              (state_q == REQ) | (state_q == RESP));

    // Load extraction works on the buffered response; EX/MEM is held so off/size are still valid.
    always_comb begin
        sh     = load_buf_q >> {off, 3'b000};
        ld_val = sh;
        case (me_mem_byte_enable)
            8'h01: ld_val = me_mem_ext_un ? {{(XLEN-8){1'b0}},  sh[7:0]}
                                          : {{(XLEN-8){sh[7]}},  sh[7:0]};
            8'h03: ld_val = me_mem_ext_un ? {{(XLEN-16){1'b0}}, sh[15:0]}
                                          : {{(XLEN-16){sh[15]}}, sh[15:0]};
            8'h0F: ld_val = me_mem_ext_un ? {{(XLEN-32){1'b0}}, sh[31:0]}
                                          : {{(XLEN-32){sh[31]}}, sh[31:0]};
            default: ld_val = sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            req_valid_q    <= 1'b0;
            req_addr_q     <= '0;
            req_wen_q      <= 1'b0;
            req_wdata_q    <= '0;
            req_wmask_q    <= '0;
            load_buf_q     <= '0;
            wb_rd_wena_q   <= 1'b0;
            wb_rd_waddr_q  <= '0;
            wb_rd_wdata_q  <= '0;
            wb_pc_q        <= '0;
            wb_inst_q      <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op && !misaligned) begin
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= {me_alu_result[XLEN-1:3], 3'b000};
                        req_wen_q   <= me_mem_wena;
                        req_wdata_q <= me_new_rs2_data << {off, 3'b000};
                        req_wmask_q <= be_wide[7:0];
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        state_q     <= RESP;
                        req_valid_q <= 1'b0;
                    end
                end
                RESP: begin
                    if (dmem_resp_valid) begin
                        load_buf_q <= dmem_rdata;
                        state_q    <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (!stall_req) begin
                wb_rd_waddr_q  <= me_rd_waddr;
                wb_pc_q        <= me_pc;
                wb_inst_q      <= me_inst;
                wb_rd_wdata_q  <= me_mem_to_reg ? ld_val : me_alu_result;
                wb_rd_wena_q   <= me_rd_wena & ~misaligned;
                misalign_err_q <= misaligned;
            end else begin
                wb_rd_wena_q   <= 1'b0;
                misalign_err_q <= 1'b0;
            end
        end
    end

    assign dmem_req_valid = req_valid_q;
    assign dmem_addr      = req_addr_q;
    assign dmem_wen       = req_wen_q;
    assign dmem_wdata     = req_wdata_q;
    assign dmem_wmask     = req_wmask_q;
    assign wb_rd_wena     = wb_rd_wena_q;
    assign wb_rd_waddr    = wb_rd_waddr_q;
    assign wb_rd_wdata    = wb_rd_wdata_q;
    assign wb_pc          = wb_pc_q;
    assign wb_inst        = wb_inst_q;
    assign misalign_err   = misalign_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU pass-through, loads/stores on a zero-wait and a slow bus,
// misaligned access, and reset in the middle of an access.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        me_mem_rena, me_mem_wena, me_mem_ext_un, me_mem_to_reg;
    logic [7:0]  me_mem_byte_enable;
    logic [63:0] me_alu_result, me_new_rs2_data;
    logic        me_rd_wena;
    logic [4:0]  me_rd_waddr;
    logic [63:0] me_pc;
    logic [31:0] me_inst;
    logic        stall_req, dmem_req_valid, dmem_req_ready;
    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wmask;
    logic        dmem_resp_valid;
    logic [63:0] dmem_rdata;
    logic        wb_rd_wena;
    logic [4:0]  wb_rd_waddr;
    logic [63:0] wb_rd_wdata, wb_pc;
    logic [31:0] wb_inst;
    logic        misalign_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_unit #(.XLEN(64), .ILEN(32)) dut (
        .clk(clk), .rst(rst),
        .me_mem_rena(me_mem_rena), .me_mem_wena(me_mem_wena),
        .me_mem_ext_un(me_mem_ext_un), .me_mem_to_reg(me_mem_to_reg),
        .me_mem_byte_enable(me_mem_byte_enable), .me_alu_result(me_alu_result),
        .me_new_rs2_data(me_new_rs2_data), .me_rd_wena(me_rd_wena),
        .me_rd_waddr(me_rd_waddr), .me_pc(me_pc), .me_inst(me_inst),
        .stall_req(stall_req), .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
        .wb_rd_wena(wb_rd_wena), .wb_rd_waddr(wb_rd_waddr), .wb_rd_wdata(wb_rd_wdata),
        .wb_pc(wb_pc), .wb_inst(wb_inst), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic rena, input logic wena, input logic ext_un,
                          input logic to_reg, input logic [7:0] be, input logic [63:0] alu,
                          input logic [63:0] rs2, input logic rdw, input logic [4:0] rd);
        me_mem_rena        = rena;
        me_mem_wena        = wena;
        me_mem_ext_un      = ext_un;
        me_mem_to_reg      = to_reg;
        me_mem_byte_enable = be;
        me_alu_result      = alu;
        me_new_rs2_data    = rs2;
        me_rd_wena         = rdw;
        me_rd_waddr        = rd;
        me_pc              = me_pc + 64'd4;
        me_inst            = me_inst + 32'd1;
    endtask

    // Plays the bus for one instruction; returns once the instruction has written WB (1 ns after that edge).
    task automatic run_op(input int ready_wait, input int resp_delay, input logic [63:0] rdata,
                          output int stalls, output int reqs, output int wb_writes,
                          output logic stable, output logic [63:0] a, output logic [63:0] wd,
                          output logic [7:0] wm, output logic we);
        bit acc;
        int acc_k;
        stalls = 0; reqs = 0; wb_writes = 0; stable = 1'b1;
        a = '0; wd = '0; wm = '0; we = 1'b0; acc = 1'b0; acc_k = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            dmem_req_ready  = (k >= ready_wait);
            dmem_resp_valid = acc && (k == acc_k + resp_delay);
            dmem_rdata      = dmem_resp_valid ? rdata : 64'hBAD0_BAD0_BAD0_BAD0;
            #1;
            if (k > 0 && wb_rd_wena) wb_writes++;
            if (dmem_req_valid) begin
                if (reqs == 0) begin
                    a = dmem_addr; wd = dmem_wdata; wm = dmem_wmask; we = dmem_wen;
                end else if (a !== dmem_addr || wd !== dmem_wdata || wm !== dmem_wmask ||
                             we !== dmem_wen) begin
                    stable = 1'b0;
                end
                reqs++;
                if (dmem_req_ready && !acc) begin
                    acc = 1'b1; acc_k = k;
                end
            end
            if (stall_req) stalls++;
            else break;
        end
        @(posedge clk);
        #1;
        dmem_resp_valid = 1'b0;
        if (wb_rd_wena) wb_writes++;
    endtask

    int          stalls, reqs, wbw;
    logic        stable, we;
    logic [63:0] a, wd;
    logic [7:0]  wm;

    initial begin
        rst = 1'b0;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = '0;
        me_pc = 64'h8000_0000; me_inst = 32'h0000_0013;
        set_op(0, 0, 0, 0, 8'h00, 64'h0, 64'h0, 0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_stall", stall_req, 0);
        check("rst_req_valid", dmem_req_valid, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wb_wena", wb_rd_wena, 0);
        check("rst_wb_wdata", wb_rd_wdata, 0);
        check("rst_misalign", misalign_err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ALU op
        set_op(0, 0, 0, 0, 8'h00, 64'h1234, 64'h0, 1, 5'd5);
        run_op(0, 1, 64'h0, stalls, reqs, wbw, stable, a, wd, wm, we);
        check("alu_stalls", stalls, 0);
        check("alu_reqs", reqs, 0);
        check("alu_wdata", wb_rd_wdata, 64'h1234);
        check("alu_waddr", wb_rd_waddr, 5);
        check("alu_wena", wb_rd_wena, 1);
        check("alu_pc", wb_pc, 64'h8000_0008);

        // LB signed, zero-wait bus
        set_op(1, 0, 0, 1, 8'h01, 64'h8000_0005, 64'h0, 1, 5'd6);
        run_op(0, 1, 64'h0011_8000_0000_0000, stalls, reqs, wbw, stable, a, wd, wm, we);
        check("lb_stalls", stalls, 3);
        check("lb_addr", a, 64'h8000_0000);
        check("lb_wen", we, 0);
        check("lb_wdata", wb_rd_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_wb_writes", wbw, 1);
        check("lb_waddr", wb_rd_waddr, 6);

        // LBU
        set_op(1, 0, 1, 1, 8'h01, 64'h8000_0005, 64'h0, 1, 5'd6);
        run_op(0, 1, 64'h0011_8000_0000_0000, stalls, reqs, wbw, stable, a, wd, wm, we);
        check("lbu_wdata", wb_rd_wdata, 64'h80);

        // SH
        set_op(0, 1, 0, 0, 8'h03, 64'h8000_0002, 64'h1234_5678_9ABC_DEF0, 0, 5'd0);
        run_op(0, 1, 64'h0, stalls, reqs, wbw, stable, a, wd, wm, we);
        check("sh_stalls", stalls, 3);
        check("sh_wen", we, 1);
        check("sh_wmask", wm, 8'h0C);
        check("sh_wdata", wd, 64'h5678_9ABC_DEF0_0000);
        check("sh_wb_wena", wb_rd_wena, 0);

        // LW on a slow bus: ready low 3 cycles, response 2 cycles after acceptance
        set_op(1, 0, 0, 1, 8'h0F, 64'h8000_0004, 64'h0, 1, 5'd9);
        run_op(4, 2, 64'h8765_4321_0000_0000, stalls, reqs, wbw, stable, a, wd, wm, we);
        check("lw_wait_stalls", stalls, 7);
        check("lw_wait_req_cycles", reqs, 4);
        check("lw_wait_stable", stable, 1);
        check("lw_wait_wb_writes", wbw, 1);
        check("lw_wait_wdata", wb_rd_wdata, 64'hFFFF_FFFF_8765_4321);

        // LD: unchanged
        set_op(1, 0, 0, 1, 8'hFF, 64'h8000_0008, 64'h0, 1, 5'd10);
        run_op(0, 1, 64'hDEAD_BEEF_0123_4567, stalls, reqs, wbw, stable, a, wd, wm, we);
        check("ld_addr", a, 64'h8000_0008);
        check("ld_wdata", wb_rd_wdata, 64'hDEAD_BEEF_0123_4567);

        // Misaligned LW
        set_op(1, 0, 0, 1, 8'h0F, 64'h8000_0006, 64'h0, 1, 5'd11);
        run_op(0, 1, 64'h0, stalls, reqs, wbw, stable, a, wd, wm, we);
        check("mis_reqs", reqs, 0);
        check("mis_stalls", stalls, 0);
        check("mis_err", misalign_err, 1);
        check("mis_wb_wena", wb_rd_wena, 0);
        set_op(0, 0, 0, 0, 8'h00, 64'h55, 64'h0, 1, 5'd12);
        run_op(0, 1, 64'h0, stalls, reqs, wbw, stable, a, wd, wm, we);
        check("mis_err_pulse", misalign_err, 0);
        check("post_mis_wena", wb_rd_wena, 1);

        // Reset while in RESP
        set_op(1, 0, 0, 1, 8'h01, 64'h8000_0005, 64'h0, 1, 5'd6);
        @(negedge clk);
        dmem_req_ready = 1'b1;
        #1;
        check("rr_idle_stall", stall_req, 1);
        @(negedge clk);
        #1;
        check("rr_req_valid", dmem_req_valid, 1);
        @(negedge clk);
        #1;
        check("rr_resp_state", {stall_req, dmem_req_valid}, 2'b10);
        #1;
        rst = 1'b0;
        #1;
        check("rr_stall_drop", stall_req, 0);
        check("rr_valid_drop", dmem_req_valid, 0);
        set_op(0, 0, 0, 0, 8'h00, 64'hABCD, 64'h0, 1, 5'd7);
        @(negedge clk);
        rst = 1'b1;
        dmem_resp_valid = 1'b1;
        dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("rr_late_resp_stall", stall_req, 0);
        @(posedge clk);
        #1;
        dmem_resp_valid = 1'b0;
        check("rr_alu_wdata", wb_rd_wdata, 64'hABCD);
        check("rr_alu_wena", wb_rd_wena, 1);
        check("rr_no_req", dmem_req_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
